// File: rtl/ticket_vendor_param.sv
// ticket_vendor_param: multi-ticket route fare seller with coin intake,
// cancel/refund and exact change. Optional `ROUND_TRIP_EN adds round_trip.
// Ports: clk, reset (sync, active-low); origin/destination/sel_valid route
// select; howManyTicket/qty_valid quantity; money/coin_valid coin intake;
// cancel abort. Outputs (all registered): costOfTicket, moneyToPay,
// totalMoney, change/change_valid, ticket_count/ticket_valid, coin_reject,
// err, busy.
module ticket_vendor_param #(
  parameter int NUM_STATIONS = 8,
  parameter int STN_W        = 3,
  parameter int QTY_W        = 3,
  parameter int MAX_TICKETS  = 6,
  parameter int BASE_FARE    = 5,
  parameter int HOP_FARE     = 5,
  parameter int COIN_W       = 6,
  parameter int MONEY_W      = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STN_W-1:0]   origin,
  input  logic [STN_W-1:0]   destination,
  input  logic               sel_valid,
`ifdef ROUND_TRIP_EN
  input  logic               round_trip,
`endif
  input  logic [QTY_W-1:0]   howManyTicket,
  input  logic               qty_valid,
  input  logic [COIN_W-1:0]  money,
  input  logic               coin_valid,
  input  logic               cancel,
  output logic [MONEY_W-1:0] costOfTicket,
  output logic [MONEY_W-1:0] moneyToPay,
  output logic [MONEY_W-1:0] totalMoney,
  output logic [MONEY_W-1:0] change,
  output logic               change_valid,
  output logic [QTY_W-1:0]   ticket_count,
  output logic               ticket_valid,
  output logic               coin_reject,
  output logic               err,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, QTY, PAY, DISPENSE, REFUND
  } state_t;

  state_t state_q, state_d;
  logic [MONEY_W-1:0] cost_q, cost_d;
  logic [MONEY_W-1:0] due_q, due_d;
  logic [MONEY_W-1:0] total_q, total_d;
  logic [MONEY_W-1:0] topay_q, topay_d;
  logic [MONEY_W-1:0] chg_q, chg_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [QTY_W-1:0]   tcnt_q, tcnt_d;
  logic chv_q, chv_d, tv_q, tv_d;
  logic rej_q, rej_d, err_q, err_d;

  logic [STN_W-1:0]   hops;
  logic [MONEY_W-1:0] one_way, fare;
  logic [MONEY_W:0]   sum;
  logic stn_ok, qty_ok, coin_ok;

  assign hops = (origin > destination) ? origin - destination
                                       : destination - origin;
  assign one_way = MONEY_W'(BASE_FARE)
                 + MONEY_W'(HOP_FARE) * MONEY_W'(hops);

`ifdef ROUND_TRIP_EN
  assign fare = round_trip ? {one_way[MONEY_W-2:0], 1'b0} : one_way;
`else
  assign fare = one_way;
`endif

  // Extra MSB keeps the range check meaningful when NUM_STATIONS == 2**STN_W
  assign stn_ok = (origin != destination)
               && ({1'b0, origin} < (STN_W+1)'(NUM_STATIONS))
               && ({1'b0, destination} < (STN_W+1)'(NUM_STATIONS));
  assign qty_ok = (howManyTicket != '0)
               && (howManyTicket <= QTY_W'(MAX_TICKETS));

  // Carry bit set means the coin would overflow the money registers
  assign sum = {1'b0, total_q} + (MONEY_W+1)'(money);
  assign coin_ok = ((money == COIN_W'(1)) || (money == COIN_W'(5))
                 || (money == COIN_W'(10)) || (money == COIN_W'(50)))
                 && !sum[MONEY_W];

  always_comb begin
    state_d = state_q;
    cost_d  = cost_q;
    due_d   = due_q;
    total_d = total_q;
    topay_d = topay_q;
    qty_d   = qty_q;
    chg_d   = '0;
    tcnt_d  = '0;
    chv_d   = 1'b0;
    tv_d    = 1'b0;
    err_d   = 1'b0;
    rej_d   = coin_valid;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          if (stn_ok) begin
            cost_d  = fare;
            state_d = QTY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      QTY: begin
        if (cancel) begin
          cost_d  = '0;
          state_d = IDLE;
        end else if (qty_valid) begin
          if (qty_ok) begin
            qty_d   = howManyTicket;
            due_d   = cost_q * MONEY_W'(howManyTicket);
            topay_d = cost_q * MONEY_W'(howManyTicket);
            state_d = PAY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PAY: begin
        rej_d = coin_valid & (cancel | ~coin_ok);
        if (cancel) begin
          chg_d   = total_q;
          chv_d   = 1'b1;
          state_d = REFUND;
        end else if (coin_valid && coin_ok) begin
          total_d = sum[MONEY_W-1:0];
          if (sum[MONEY_W-1:0] >= due_q) begin
            topay_d = '0;
            chg_d   = sum[MONEY_W-1:0] - due_q;
            chv_d   = 1'b1;
            tv_d    = 1'b1;
            tcnt_d  = qty_q;
            state_d = DISPENSE;
          end else begin
            topay_d = due_q - sum[MONEY_W-1:0];
          end
        end
      end
      DISPENSE, REFUND: begin
        cost_d  = '0;
        due_d   = '0;
        total_d = '0;
        topay_d = '0;
        qty_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cost_q  <= '0;
      due_q   <= '0;
      total_q <= '0;
      topay_q <= '0;
      qty_q   <= '0;
      chg_q   <= '0;
      tcnt_q  <= '0;
      chv_q   <= 1'b0;
      tv_q    <= 1'b0;
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cost_q  <= cost_d;
      due_q   <= due_d;
      total_q <= total_d;
      topay_q <= topay_d;
      qty_q   <= qty_d;
      chg_q   <= chg_d;
      tcnt_q  <= tcnt_d;
      chv_q   <= chv_d;
      tv_q    <= tv_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
    end
  end

  assign costOfTicket = cost_q;
  assign moneyToPay   = topay_q;
  assign totalMoney   = total_q;
  assign change       = chg_q;
  assign change_valid = chv_q;
  assign ticket_count = tcnt_q;
  assign ticket_valid = tv_q;
  assign coin_reject  = rej_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ticket_vendor_param.sv
// tb_ticket_vendor_param: scenario tasks with a change/ticket scoreboard
// for ticket_vendor_param.
module tb_ticket_vendor_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] origin, destination, howManyTicket;
  logic       sel_valid, qty_valid, coin_valid, cancel;
  logic [5:0] money;
`ifdef ROUND_TRIP_EN
  logic       rt;
`endif
  logic [8:0] costOfTicket, moneyToPay, totalMoney, change;
  logic [2:0] ticket_count;
  logic       change_valid, ticket_valid, coin_reject, err, busy;

  typedef struct {
    logic [8:0] chg;
    logic       tv;
    logic [2:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   got;

  ticket_vendor_param dut (
    .clk(clk), .reset(reset),
    .origin(origin), .destination(destination), .sel_valid(sel_valid),
`ifdef ROUND_TRIP_EN
    .round_trip(rt),
`endif
    .howManyTicket(howManyTicket), .qty_valid(qty_valid),
    .money(money), .coin_valid(coin_valid), .cancel(cancel),
    .costOfTicket(costOfTicket), .moneyToPay(moneyToPay),
    .totalMoney(totalMoney), .change(change),
    .change_valid(change_valid), .ticket_count(ticket_count),
    .ticket_valid(ticket_valid), .coin_reject(coin_reject),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    sel_valid  = 1'b0;
    qty_valid  = 1'b0;
    coin_valid = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic do_sel(input int o, input int d);
    origin = 3'(o); destination = 3'(d); sel_valid = 1'b1;
`ifdef ROUND_TRIP_EN
    rt = 1'b0;
`endif
    step();
  endtask

  task automatic do_qty(input int q);
    howManyTicket = 3'(q); qty_valid = 1'b1;
    step();
  endtask

  task automatic do_coin(input int m, input bit cn);
    money = 6'(m); coin_valid = 1'b1; cancel = cn;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({costOfTicket, moneyToPay, totalMoney, change, change_valid,
         ticket_count, ticket_valid, coin_reject, err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got cost=%0d pay=%0d tot=%0d busy=%b want all 0",
               costOfTicket, moneyToPay, totalMoney, busy);
    end
    reset = 1'b1;
    do_coin(10, 1'b0);
    n_cmp++;
    if ({coin_reject, totalMoney, busy} !== {1'b1, 9'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_coin: got rej=%b tot=%0d busy=%b want 1 0 0",
               coin_reject, totalMoney, busy);
    end
  endtask

  task automatic test_cancel_refund();
    do_sel(2, 5);
    n_cmp++;
    if ({costOfTicket, busy} !== {9'd20, 1'b1}) begin
      n_bad++;
      $display("FAIL refund_cost: got %0d busy=%b want 20 1", costOfTicket, busy);
    end
    do_qty(2);
    n_cmp++;
    if (moneyToPay !== 9'd40) begin
      n_bad++;
      $display("FAIL refund_due: got %0d want 40", moneyToPay);
    end
    for (int i = 1; i <= 2; i++) begin
      do_coin(10, 1'b0);
      n_cmp++;
      if ({totalMoney, moneyToPay} !== {9'(10 * i), 9'(40 - 10 * i)}) begin
        n_bad++;
        $display("FAIL refund_coin%0d: got tot=%0d pay=%0d want %0d %0d",
                 i, totalMoney, moneyToPay, 10 * i, 40 - 10 * i);
      end
    end
    sbq.push_back('{chg: 9'd20, tv: 1'b0, cnt: 3'd0});
    cancel = 1'b1;
    step();
    got = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!got) begin
        if (change_valid) got = 1'b1;
        else step();
      end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL refund_timeout: got no change_valid want pulse");
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if ({change, ticket_valid, ticket_count} !== {e.chg, e.tv, e.cnt}) begin
        n_bad++;
        $display("FAIL refund_change: got chg=%0d tv=%b cnt=%0d want %0d %b %0d",
                 change, ticket_valid, ticket_count, e.chg, e.tv, e.cnt);
      end
    end
    step();
    n_cmp++;
    if ({change_valid, busy, totalMoney, costOfTicket} !== '0) begin
      n_bad++;
      $display("FAIL refund_after: got chv=%b busy=%b tot=%0d cost=%0d want 0",
               change_valid, busy, totalMoney, costOfTicket);
    end
  endtask

  task automatic test_exact_change();
    int coins[5] = '{50, 10, 5, 5, 10};
    int tots[5]  = '{50, 60, 65, 70, 80};
    int pays[5]  = '{25, 15, 10, 5, 0};
    do_sel(3, 5);
    do_qty(5);
    n_cmp++;
    if ({costOfTicket, moneyToPay} !== {9'd15, 9'd75}) begin
      n_bad++;
      $display("FAIL exact_due: got cost=%0d pay=%0d want 15 75",
               costOfTicket, moneyToPay);
    end
    do_sel(0, 7);
    n_cmp++;
    if (costOfTicket !== 9'd15) begin
      n_bad++;
      $display("FAIL sel_in_pay: got %0d want 15", costOfTicket);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) sbq.push_back('{chg: 9'd5, tv: 1'b1, cnt: 3'd5});
      do_coin(coins[i], 1'b0);
      n_cmp++;
      if ({totalMoney, moneyToPay} !== {9'(tots[i]), 9'(pays[i])}) begin
        n_bad++;
        $display("FAIL exact_coin%0d: got tot=%0d pay=%0d want %0d %0d",
                 i, totalMoney, moneyToPay, tots[i], pays[i]);
      end
    end
    got = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!got) begin
        if (change_valid) got = 1'b1;
        else step();
      end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL exact_timeout: got no change_valid want pulse");
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if ({change, ticket_valid, ticket_count} !== {e.chg, e.tv, e.cnt}) begin
        n_bad++;
        $display("FAIL exact_change: got chg=%0d tv=%b cnt=%0d want %0d %b %0d",
                 change, ticket_valid, ticket_count, e.chg, e.tv, e.cnt);
      end
    end
    step();
    n_cmp++;
    if ({change_valid, ticket_valid, busy, totalMoney} !== '0) begin
      n_bad++;
      $display("FAIL exact_after: got chv=%b tv=%b busy=%b tot=%0d want 0",
               change_valid, ticket_valid, busy, totalMoney);
    end
  endtask

  task automatic test_illegal_and_coins();
    do_sel(4, 4);
    n_cmp++;
    if ({err, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL same_station: got err=%b busy=%b want 1 0", err, busy);
    end
    do_sel(5, 2);
    n_cmp++;
    if ({costOfTicket, err} !== {9'd20, 1'b0}) begin
      n_bad++;
      $display("FAIL rev_route: got cost=%0d err=%b want 20 0", costOfTicket, err);
    end
    do_qty(0);
    n_cmp++;
    if ({err, busy, moneyToPay} !== {2'b11, 9'd0}) begin
      n_bad++;
      $display("FAIL qty0: got err=%b busy=%b pay=%0d want 1 1 0", err, busy, moneyToPay);
    end
    do_qty(7);
    n_cmp++;
    if ({err, moneyToPay} !== {1'b1, 9'd0}) begin
      n_bad++;
      $display("FAIL qty7: got err=%b pay=%0d want 1 0", err, moneyToPay);
    end
    do_qty(1);
    n_cmp++;
    if ({err, moneyToPay} !== {1'b0, 9'd20}) begin
      n_bad++;
      $display("FAIL qty1: got err=%b pay=%0d want 0 20", err, moneyToPay);
    end
    do_coin(3, 1'b0);
    n_cmp++;
    if ({coin_reject, totalMoney} !== {1'b1, 9'd0}) begin
      n_bad++;
      $display("FAIL coin3: got rej=%b tot=%0d want 1 0", coin_reject, totalMoney);
    end
    sbq.push_back('{chg: 9'd0, tv: 1'b0, cnt: 3'd0});
    do_coin(10, 1'b1);
    n_cmp++;
    if ({coin_reject, change_valid} !== 2'b11) begin
      n_bad++;
      $display("FAIL coin_cancel: got rej=%b chv=%b want 1 1", coin_reject, change_valid);
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if ({change, ticket_valid} !== {e.chg, e.tv}) begin
        n_bad++;
        $display("FAIL coin_cancel_refund: got chg=%0d tv=%b want %0d %b",
                 change, ticket_valid, e.chg, e.tv);
      end
    end
    step();
    do_sel(5, 2);
    do_qty(1);
    do_coin(10, 1'b0);
    sbq.push_back('{chg: 9'd0, tv: 1'b1, cnt: 3'd1});
    do_coin(10, 1'b0);
    n_cmp++;
    if (!change_valid) begin
      n_bad++;
      $display("FAIL exact20_pulse: got chv=0 want 1");
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if ({change, ticket_valid, ticket_count} !== {e.chg, e.tv, e.cnt}) begin
        n_bad++;
        $display("FAIL exact20: got chg=%0d tv=%b cnt=%0d want %0d %b %0d",
                 change, ticket_valid, ticket_count, e.chg, e.tv, e.cnt);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_pay();
    do_sel(1, 3);
    do_qty(3);
    repeat (3) do_coin(10, 1'b0);
    n_cmp++;
    if ({totalMoney, moneyToPay} !== {9'd30, 9'd15}) begin
      n_bad++;
      $display("FAIL mid_total: got tot=%0d pay=%0d want 30 15", totalMoney, moneyToPay);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++;
    if ({costOfTicket, moneyToPay, totalMoney, change, change_valid,
         ticket_valid, busy} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got tot=%0d chv=%b busy=%b want 0 0 0",
               totalMoney, change_valid, busy);
    end
    step();
    n_cmp++;
    if ({change_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_reset_after: got chv=%b busy=%b want 0 0", change_valid, busy);
    end
    do_sel(0, 1);
    do_qty(1);
    n_cmp++;
    if (moneyToPay !== 9'd10) begin
      n_bad++;
      $display("FAIL post_reset_due: got %0d want 10", moneyToPay);
    end
    sbq.push_back('{chg: 9'd0, tv: 1'b1, cnt: 3'd1});
    do_coin(10, 1'b0);
    n_cmp++;
    if (!change_valid) begin
      n_bad++;
      $display("FAIL post_reset_pulse: got chv=0 want 1");
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if ({change, ticket_valid, ticket_count} !== {e.chg, e.tv, e.cnt}) begin
        n_bad++;
        $display("FAIL post_reset: got chg=%0d tv=%b cnt=%0d want %0d %b %0d",
                 change, ticket_valid, ticket_count, e.chg, e.tv, e.cnt);
      end
    end
    step();
  endtask

`ifdef ROUND_TRIP_EN
  task automatic test_round_trip();
    origin = 3'd0; destination = 3'd7; rt = 1'b1; sel_valid = 1'b1;
    step();
    rt = 1'b0;
    n_cmp++;
    if (costOfTicket !== 9'd80) begin
      n_bad++;
      $display("FAIL rt_cost: got %0d want 80", costOfTicket);
    end
    do_qty(1);
    do_coin(50, 1'b0);
    sbq.push_back('{chg: 9'd20, tv: 1'b1, cnt: 3'd1});
    do_coin(50, 1'b0);
    n_cmp++;
    if (!change_valid) begin
      n_bad++;
      $display("FAIL rt_pulse: got chv=0 want 1");
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if ({change, ticket_valid, ticket_count} !== {e.chg, e.tv, e.cnt}) begin
        n_bad++;
        $display("FAIL rt_change: got chg=%0d tv=%b cnt=%0d want %0d %b %0d",
                 change, ticket_valid, ticket_count, e.chg, e.tv, e.cnt);
      end
    end
    step();
  endtask
`endif

  initial begin
    origin = '0; destination = '0; howManyTicket = '0; money = '0;
    sel_valid = 1'b0; qty_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
`ifdef ROUND_TRIP_EN
    rt = 1'b0;
`endif
    test_reset();
    test_cancel_refund();
    test_exact_change();
    test_illegal_and_coins();
    test_reset_mid_pay();
`ifdef ROUND_TRIP_EN
    test_round_trip();
`endif
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
